// File: rtl/sccb_target_responder_pkg.sv
// Shared SCCB responder definitions: FSM encodings, default device ID, bus ACK level
// and the ID comparison helper used by the responder and its test environment.
package sccb_target_responder_pkg;

  localparam logic [7:0] SCCB_DEFAULT_ID = 8'h42;
  localparam logic       SCCB_ACK_LEVEL  = 1'b0;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ID        = 4'd1;
  localparam logic [3:0] ST_ID_ACK    = 4'd2;
  localparam logic [3:0] ST_SUB       = 4'd3;
  localparam logic [3:0] ST_SUB_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RD_NA     = 4'd8;
  localparam logic [3:0] ST_IGNORE    = 4'd9;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } sccb_wr_t;

  // The R/W bit (bit 0) never takes part in the address match.
  function automatic logic sccb_id_match(input logic [7:0] id, input logic [7:0] dev);
    return (id | 8'h01) == (dev | 8'h01);
  endfunction

endpackage

// File: rtl/sccb_target_responder_if.sv
// SCCB pad signals plus the external register port of the responder.
interface sccb_target_responder_if;

  logic       sio_c;
  logic       sio_d_in;
  logic       sio_d_oe;
  logic       reg_we;
  logic [7:0] reg_waddr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_raddr;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       txn_done;

  modport slave (
    input  sio_c,
    input  sio_d_in,
    input  reg_rdata,
    output sio_d_oe,
    output reg_we,
    output reg_waddr,
    output reg_wdata,
    output reg_raddr,
    output busy,
    output txn_done
  );

  modport master (
    output sio_c,
    output sio_d_in,
    output reg_rdata,
    input  sio_d_oe,
    input  reg_we,
    input  reg_waddr,
    input  reg_wdata,
    input  reg_raddr,
    input  busy,
    input  txn_done
  );

endinterface

// File: rtl/sccb_target_responder_line_sync.sv
// Synchronises the asynchronous SIO_C/SIO_D lines into PCLK and derives the
// SCL edge strobes plus START/STOP conditions from the synchronised levels.
module sccb_target_responder_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic PCLK,
  input  logic PRESETN,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_sda
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  // Idle bus is pulled high, so the chains reset to 1 to avoid a false edge.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_scl_sync <= {SYNC_STAGES{1'b1}};
      r_sda_sync <= {SYNC_STAGES{1'b1}};
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  assign o_scl_rise = w_scl & ~r_scl_d;
  assign o_scl_fall = ~w_scl & r_scl_d;
  assign o_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign o_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign o_sda      = w_sda;

endmodule

// File: rtl/sccb_target_responder.sv
// SCCB target responder: decodes 3-phase/2-phase writes and 2-phase reads, drives
// ACK and read data open-drain, and talks to external register storage.
module sccb_target_responder
  import sccb_target_responder_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID   = SCCB_DEFAULT_ID,
  parameter int         SYNC_STAGES = 2,
  parameter bit         ACK_EN      = 1'b1
) (
  input logic                    PCLK,
  input logic                    PRESETN,
  sccb_target_responder_if.slave io_sccb
);

  localparam logic LP_ACK_OE = ACK_EN && (SCCB_ACK_LEVEL == 1'b0);

  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic       w_sda;
  logic [7:0] w_byte;

  logic [3:0] r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_tx;
  logic [7:0] r_sub_addr;
  sccb_wr_t   r_wr;
  logic       r_we;
  logic       r_oe;
  logic       r_busy;
  logic       r_txn_done;
  logic       r_rd;
  logic       r_ack_hold;

  sccb_target_responder_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .PCLK       (PCLK),
    .PRESETN    (PRESETN),
    .i_scl      (io_sccb.sio_c),
    .i_sda      (io_sccb.sio_d_in),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop),
    .o_sda      (w_sda)
  );

  assign w_byte = {r_shift[6:0], w_sda};

  // Bus conditions outrank SCL edges; bits are taken on rise, target bits change on fall.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_tx       <= 8'h00;
      r_sub_addr <= 8'h00;
      r_wr       <= 16'h0000;
      r_we       <= 1'b0;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_txn_done <= 1'b0;
      r_rd       <= 1'b0;
      r_ack_hold <= 1'b0;
    end else begin
      r_we       <= 1'b0;
      r_txn_done <= 1'b0;
      if (w_stop) begin
        r_state    <= ST_IDLE;
        r_oe       <= 1'b0;
        r_busy     <= 1'b0;
        r_txn_done <= r_busy;
        r_ack_hold <= 1'b0;
      end else if (w_start) begin
        r_state    <= ST_ID;
        r_bit_cnt  <= 3'd0;
        r_oe       <= 1'b0;
        r_ack_hold <= 1'b0;
      end else if (w_scl_rise) begin
        case (r_state)
          ST_ID, ST_SUB, ST_WDATA: begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              case (r_state)
                ST_ID: begin
                  if (sccb_id_match(w_byte, DEVICE_ID)) begin
                    r_busy  <= 1'b1;
                    r_rd    <= w_byte[0];
                    r_state <= ST_ID_ACK;
                  end else begin
                    r_state <= ST_IGNORE;
                  end
                end
                ST_SUB: begin
                  r_sub_addr <= w_byte;
                  r_state    <= ST_SUB_ACK;
                end
                default: begin
                  r_wr    <= {r_sub_addr, w_byte};
                  r_we    <= 1'b1;
                  r_state <= ST_WDATA_ACK;
                end
              endcase
            end
          end
          ST_RD_NA: begin
            r_state <= ST_IGNORE;
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end else if (w_scl_fall) begin
        case (r_state)
          ST_ID_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
            if (!r_ack_hold) begin
              r_oe       <= LP_ACK_OE;
              r_ack_hold <= 1'b1;
            end else begin
              r_ack_hold <= 1'b0;
              r_bit_cnt  <= 3'd0;
              case (r_state)
                ST_ID_ACK: begin
                  if (r_rd) begin
                    // First read bit goes out on the same edge that ends the ACK slot.
                    r_tx    <= {io_sccb.reg_rdata[6:0], 1'b0};
                    r_oe    <= ~io_sccb.reg_rdata[7];
                    r_state <= ST_RDATA;
                  end else begin
                    r_oe    <= 1'b0;
                    r_state <= ST_SUB;
                  end
                end
                ST_SUB_ACK: begin
                  r_oe    <= 1'b0;
                  r_state <= ST_WDATA;
                end
                default: begin
                  r_oe    <= 1'b0;
                  r_state <= ST_IGNORE;
                end
              endcase
            end
          end
          ST_RDATA: begin
            if (r_bit_cnt == 3'd7) begin
              r_oe    <= 1'b0;
              r_state <= ST_RD_NA;
            end else begin
              r_oe      <= ~r_tx[7];
              r_tx      <= {r_tx[6:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign io_sccb.sio_d_oe  = r_oe;
  assign io_sccb.reg_we    = r_we;
  assign io_sccb.reg_waddr = r_wr.addr;
  assign io_sccb.reg_wdata = r_wr.data;
  assign io_sccb.reg_raddr = r_sub_addr;
  assign io_sccb.busy      = r_busy;
  assign io_sccb.txn_done  = r_txn_done;

endmodule

// File: tb/tb_sccb_target_responder.sv
// Bench for sccb_target_responder: 100 kHz SCCB master on a wired-AND SIO_D, a 256x8
// register model, and scoreboard queues for expected writes and read bytes.
module tb_sccb_target_responder;
  import sccb_target_responder_pkg::*;

  localparam int Q = 2500;

  logic PCLK    = 1'b0;
  logic PRESETN = 1'b0;
  logic m_scl   = 1'b1;
  logic m_sda   = 1'b1;

  logic [7:0]  mem [256];
  logic [15:0] q_wr [$];
  logic [7:0]  q_rd [$];
  int          n_chk = 0;
  int          n_err = 0;
  int          n_we = 0;
  int          n_done = 0;
  logic        oe_seen = 1'b0;

  always #50 PCLK = ~PCLK;

  sccb_target_responder_if bus0();
  sccb_target_responder_if bus1();

  assign bus0.sio_c     = m_scl;
  assign bus0.sio_d_in  = m_sda & ~bus0.sio_d_oe;
  assign bus0.reg_rdata = mem[bus0.reg_raddr];
  assign bus1.sio_c     = m_scl;
  assign bus1.sio_d_in  = bus0.sio_d_in;
  assign bus1.reg_rdata = 8'h00;

  sccb_target_responder #(.DEVICE_ID(8'h42), .SYNC_STAGES(2), .ACK_EN(1'b1)) dut0 (
    .PCLK(PCLK), .PRESETN(PRESETN), .io_sccb(bus0.slave));
  sccb_target_responder #(.DEVICE_ID(8'h42), .SYNC_STAGES(2), .ACK_EN(1'b0)) dut1 (
    .PCLK(PCLK), .PRESETN(PRESETN), .io_sccb(bus1.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Register model plus write scoreboard; sampled away from the active edge.
  always @(negedge PCLK) begin
    logic [15:0] e;
    if (bus0.reg_we === 1'b1) begin
      n_we++;
      mem[bus0.reg_waddr] = bus0.reg_wdata;
      if (q_wr.size() == 0) begin
        chk("we_unexpected", 32'(bus0.reg_we), 32'd0);
      end else begin
        e = q_wr.pop_front();
        chk("waddr", 32'(bus0.reg_waddr), 32'(e[15:8]));
        chk("wdata", 32'(bus0.reg_wdata), 32'(e[7:0]));
      end
    end
    if (bus0.txn_done === 1'b1) n_done++;
    if (bus0.sio_d_oe === 1'b1) oe_seen = 1'b1;
  end

  task automatic m_bit(input logic v);
    #Q m_sda = v;
    #Q m_scl = 1'b1;
    #(2*Q) m_scl = 1'b0;
  endtask

  task automatic m_start();
    m_sda = 1'b1; m_scl = 1'b1;
    #Q m_sda = 1'b0;
    #Q m_scl = 1'b0;
  endtask

  task automatic m_rstart();
    #Q m_sda = 1'b1;
    #Q m_scl = 1'b1;
    #Q m_sda = 1'b0;
    #Q m_scl = 1'b0;
  endtask

  task automatic m_stop();
    #Q m_sda = 1'b0;
    #Q m_scl = 1'b1;
    #Q m_sda = 1'b1;
    #Q;
  endtask

  task automatic m_byte(input logic [7:0] b, input logic exp_sda, input string tag);
    for (int i = 7; i >= 0; i--) m_bit(b[i]);
    #Q m_sda = 1'b1;
    #Q m_scl = 1'b1;
    #Q;
    chk({tag, "_ack"}, 32'(bus0.sio_d_in), 32'(exp_sda));
    chk({tag, "_ack_en0_oe"}, 32'(bus1.sio_d_oe), 32'd0);
    #Q m_scl = 1'b0;
  endtask

  task automatic m_read(output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #(2*Q) m_scl = 1'b1;
      #Q b[i] = bus0.sio_d_in;
      #Q m_scl = 1'b0;
    end
    #(2*Q) m_scl = 1'b1;
    #(2*Q) m_scl = 1'b0;
  endtask

  task automatic rd_check(input string tag);
    logic [7:0] got;
    logic [7:0] exp;
    m_read(got);
    if (q_rd.size() == 0) begin
      chk({tag, "_rd_unexpected"}, 32'(got), 32'hFFFF_FFFF);
    end else begin
      exp = q_rd.pop_front();
      chk({tag, "_rdata"}, 32'(got), 32'(exp));
    end
  endtask

  initial begin
    int we0;
    int done0;
    #20_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int we0;
    int done0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h0A] = 8'h76;
    mem[8'h05] = 8'hA5;

    #1000;
    chk("rst_oe", 32'(bus0.sio_d_oe), 32'd0);
    chk("rst_we", 32'(bus0.reg_we), 32'd0);
    chk("rst_waddr", 32'(bus0.reg_waddr), 32'd0);
    chk("rst_wdata", 32'(bus0.reg_wdata), 32'd0);
    chk("rst_raddr", 32'(bus0.reg_raddr), 32'd0);
    chk("rst_busy", 32'(bus0.busy), 32'd0);
    chk("rst_done", 32'(bus0.txn_done), 32'd0);
    chk("rst_state", 32'(dut0.r_state), 32'(ST_IDLE));
    PRESETN = 1'b1;
    #(4*Q);

    // 3-phase write
    we0 = n_we; done0 = n_done;
    q_wr.push_back({8'h12, 8'h80});
    m_start();
    m_byte(8'h42, SCCB_ACK_LEVEL, "w3_id");
    chk("w3_busy", 32'(bus0.busy), 32'd1);
    m_byte(8'h12, SCCB_ACK_LEVEL, "w3_sub");
    m_byte(8'h80, SCCB_ACK_LEVEL, "w3_data");
    m_stop();
    chk("w3_we_count", 32'(n_we - we0), 32'd1);
    chk("w3_q_empty", 32'(q_wr.size()), 32'd0);
    chk("w3_done", 32'(n_done - done0), 32'd1);
    chk("w3_busy_end", 32'(bus0.busy), 32'd0);

    // 2-phase write then read
    we0 = n_we; done0 = n_done;
    m_start();
    m_byte(8'h42, SCCB_ACK_LEVEL, "w2_id");
    m_byte(8'h0A, SCCB_ACK_LEVEL, "w2_sub");
    m_stop();
    q_rd.push_back(8'h76);
    m_start();
    m_byte(8'h43, SCCB_ACK_LEVEL, "rd_id");
    chk("rd_raddr", 32'(bus0.reg_raddr), 32'h0A);
    rd_check("rd");
    m_stop();
    chk("rd_done", 32'(n_done - done0), 32'd2);
    chk("rd_no_we", 32'(n_we - we0), 32'd0);

    // foreign ID
    we0 = n_we; done0 = n_done; oe_seen = 1'b0;
    m_start();
    m_byte(8'h60, 1'b1, "nid_id");
    chk("nid_busy", 32'(bus0.busy), 32'd0);
    m_byte(8'h12, 1'b1, "nid_sub");
    m_byte(8'h55, 1'b1, "nid_data");
    m_stop();
    chk("nid_oe_seen", 32'(oe_seen), 32'd0);
    chk("nid_we", 32'(n_we - we0), 32'd0);
    chk("nid_done", 32'(n_done - done0), 32'd0);

    // STOP in the middle of a data byte
    we0 = n_we; done0 = n_done;
    m_start();
    m_byte(8'h42, SCCB_ACK_LEVEL, "ab_id");
    m_byte(8'h20, SCCB_ACK_LEVEL, "ab_sub");
    m_bit(1'b1); m_bit(1'b0); m_bit(1'b1); m_bit(1'b0);
    m_stop();
    chk("ab_we", 32'(n_we - we0), 32'd0);
    chk("ab_state", 32'(dut0.r_state), 32'(ST_IDLE));
    chk("ab_oe", 32'(bus0.sio_d_oe), 32'd0);
    chk("ab_busy", 32'(bus0.busy), 32'd0);
    chk("ab_raddr", 32'(bus0.reg_raddr), 32'h20);
    chk("ab_done", 32'(n_done - done0), 32'd1);

    // repeated START into a read
    we0 = n_we; done0 = n_done;
    q_rd.push_back(8'hA5);
    m_start();
    m_byte(8'h42, SCCB_ACK_LEVEL, "rs_id");
    m_byte(8'h05, SCCB_ACK_LEVEL, "rs_sub");
    m_rstart();
    m_byte(8'h43, SCCB_ACK_LEVEL, "rs_rid");
    rd_check("rs");
    m_stop();
    chk("rs_we", 32'(n_we - we0), 32'd0);
    chk("rs_done", 32'(n_done - done0), 32'd1);
    chk("rs_q_empty", 32'(q_rd.size()), 32'd0);

    // async reset while driving a read 0
    done0 = n_done;
    m_start();
    m_byte(8'h42, SCCB_ACK_LEVEL, "ar_id");
    m_byte(8'h0A, SCCB_ACK_LEVEL, "ar_sub");
    m_rstart();
    m_byte(8'h43, SCCB_ACK_LEVEL, "ar_rid");
    #Q;
    chk("ar_pre_oe", 32'(bus0.sio_d_oe), 32'd1);
    PRESETN = 1'b0;
    #1;
    chk("ar_oe", 32'(bus0.sio_d_oe), 32'd0);
    chk("ar_raddr", 32'(bus0.reg_raddr), 32'd0);
    chk("ar_busy", 32'(bus0.busy), 32'd0);
    #201 PRESETN = 1'b1;
    m_stop();
    chk("ar_done", 32'(n_done - done0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
